// File: rtl/keypad_pkg.sv
// Shared types and default key-code map for the calculator keypad scanner.
// Codes are col*N_ROWS + row on the 4x4 layout: rows 1 4 7 C / 2 5 8 0 / 3 6 9 . / + - = ...
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} scan_state_t;

  typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_class_t;

  localparam int unsigned KEY_W = 4;

  localparam logic [KEY_W-1:0] KEY_1    = 4'd0;
  localparam logic [KEY_W-1:0] KEY_4    = 4'd1;
  localparam logic [KEY_W-1:0] KEY_7    = 4'd2;
  localparam logic [KEY_W-1:0] KEY_2    = 4'd4;
  localparam logic [KEY_W-1:0] KEY_5    = 4'd5;
  localparam logic [KEY_W-1:0] KEY_8    = 4'd6;
  localparam logic [KEY_W-1:0] KEY_0    = 4'd7;
  localparam logic [KEY_W-1:0] KEY_3    = 4'd8;
  localparam logic [KEY_W-1:0] KEY_6    = 4'd9;
  localparam logic [KEY_W-1:0] KEY_9    = 4'd10;
  localparam logic [KEY_W-1:0] KEY_PLUS = 4'd12;
  localparam logic [KEY_W-1:0] KEY_MIN  = 4'd13;
  localparam logic [KEY_W-1:0] KEY_EQ   = 4'd14;

endpackage

// File: rtl/keypad_col_scan.sv
// Column strobe ring, row synchroniser and full-matrix frame assembly.
// Emits one registered frame_done pulse per frame with its classification.
module keypad_col_scan
  import keypad_pkg::*;
#(
  parameter int unsigned N_ROWS   = 4,
  parameter int unsigned N_COLS   = 4,
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned CODE_W   = $clog2(N_ROWS * N_COLS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_ROWS-1:0]   rows,
  output logic [N_COLS-1:0]   cols,
  output logic                frame_done,
  output frame_class_t        frame_class,
  output logic [CODE_W-1:0]   frame_code
);

  localparam int unsigned N_KEYS = N_ROWS * N_COLS;
  localparam int unsigned ACC_W  = N_KEYS - N_ROWS;
  localparam int unsigned DIV_W  = $clog2(SCAN_DIV);
  localparam int unsigned COL_W  = $clog2(N_COLS);

  logic [N_ROWS-1:0] sync1;
  logic [N_ROWS-1:0] sync2;
  logic [DIV_W-1:0]  dwell;
  logic [COL_W-1:0]  col_idx;
  logic [ACC_W-1:0]  frame_acc;
  logic [N_KEYS-1:0] frame_next;
  logic              sample;
  logic              last_col;
  logic [1:0]        ones;
  logic [CODE_W-1:0] hit;
  frame_class_t      cls;

  assign sample   = (dwell == DIV_W'(SCAN_DIV - 1));
  assign last_col = (col_idx == COL_W'(N_COLS - 1));
  // New column enters at the top, so column 0 ends up in the low bits.
  assign frame_next = {sync2, frame_acc};

  // Classify the completed frame: count set bits (saturating at 2) and remember one index.
  always_comb begin
    ones = 2'd0;
    hit  = '0;
    for (int i = 0; i < int'(N_KEYS); i++) begin
      if (frame_next[i]) begin
        hit = CODE_W'(i);
        if (ones != 2'd2) ones = ones + 2'd1;
      end
    end
    case (ones)
      2'd0:    cls = NONE;
      2'd1:    cls = SINGLE;
      default: cls = MULTI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= '0;
      sync2       <= '0;
      dwell       <= '0;
      col_idx     <= '0;
      cols        <= N_COLS'(1);
      frame_acc   <= '0;
      frame_done  <= 1'b0;
      frame_class <= NONE;
      frame_code  <= '0;
    end else begin
      sync1      <= rows;
      sync2      <= sync1;
      frame_done <= 1'b0;
      if (sample) begin
        dwell     <= '0;
        cols      <= {cols[N_COLS-2:0], cols[N_COLS-1]};
        frame_acc <= frame_next[N_KEYS-1:N_ROWS];
        if (last_col) begin
          col_idx     <= '0;
          frame_done  <= 1'b1;
          frame_class <= cls;
          frame_code  <= hit;
        end else begin
          col_idx <= col_idx + COL_W'(1);
        end
      end else begin
        dwell <= dwell + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: frame-level debounce, press/release events,
// multi-key flag and optional auto-repeat on a held key.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned N_ROWS        = 4,
  parameter int unsigned N_COLS        = 4,
  parameter int unsigned SCAN_DIV      = 1000,
  parameter int unsigned DEBOUNCE      = 4,
  parameter int unsigned REPEAT_FRAMES = 0,
  parameter int unsigned CODE_W        = $clog2(N_ROWS * N_COLS)
) (
  input  logic              clk,
  input  logic              reset,
  output logic [N_COLS-1:0] cols,
  input  logic [N_ROWS-1:0] rows,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  output logic              key_held,
  output logic              key_release,
  output logic              multi_key
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE + 1);
  localparam int unsigned RP_W = (REPEAT_FRAMES > 0) ? $clog2(REPEAT_FRAMES + 1) : 1;

  logic              frame_done;
  frame_class_t      frame_class;
  logic [CODE_W-1:0] frame_code;

  scan_state_t       state, state_n;
  logic [DB_W-1:0]   cnt, cnt_n, cnt_inc;
  logic [RP_W-1:0]   rep, rep_n, rep_inc;
  logic [CODE_W-1:0] cand, cand_n, code_n;
  logic              valid_n, held_n, release_n, multi_n;
  logic              single, match_cand, match_key;
  logic              do_accept, do_release;

  keypad_col_scan #(
    .N_ROWS   (N_ROWS),
    .N_COLS   (N_COLS),
    .SCAN_DIV (SCAN_DIV),
    .CODE_W   (CODE_W)
  ) u_col_scan (
    .clk         (clk),
    .reset       (reset),
    .rows        (rows),
    .cols        (cols),
    .frame_done  (frame_done),
    .frame_class (frame_class),
    .frame_code  (frame_code)
  );

  assign single     = (frame_class == SINGLE);
  assign match_cand = single && (frame_code == cand);
  assign match_key  = single && (frame_code == key_code);
  assign cnt_inc    = cnt + DB_W'(1);
  assign rep_inc    = rep + RP_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rep         <= '0;
      cand        <= '0;
      key_valid   <= 1'b0;
      key_code    <= '0;
      key_held    <= 1'b0;
      key_release <= 1'b0;
      multi_key   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      rep         <= rep_n;
      cand        <= cand_n;
      key_valid   <= valid_n;
      key_code    <= code_n;
      key_held    <= held_n;
      key_release <= release_n;
      multi_key   <= multi_n;
    end
  end

  // All decisions happen on frame_done; MULTI frames never match candidate or held key.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    rep_n      = rep;
    cand_n     = cand;
    code_n     = key_code;
    held_n     = key_held;
    valid_n    = 1'b0;
    release_n  = 1'b0;
    multi_n    = multi_key;
    do_accept  = 1'b0;
    do_release = 1'b0;

    if (frame_done) begin
      multi_n = (frame_class == MULTI);
      unique case (state)
        IDLE: begin
          if (single) begin
            cand_n = frame_code;
            if (DEBOUNCE == 1) begin
              do_accept = 1'b1;
            end else begin
              cnt_n   = DB_W'(1);
              state_n = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (match_cand) begin
            if (cnt_inc == DB_W'(DEBOUNCE)) do_accept = 1'b1;
            else                            cnt_n = cnt_inc;
          end else if (single) begin
            cand_n = frame_code;
            cnt_n  = DB_W'(1);
          end else begin
            cnt_n   = '0;
            state_n = IDLE;
          end
        end
        HELD: begin
          if (match_key) begin
            if (REPEAT_FRAMES > 0) begin
              if (rep_inc == RP_W'(REPEAT_FRAMES)) begin
                valid_n = 1'b1;
                rep_n   = '0;
              end else begin
                rep_n = rep_inc;
              end
            end
          end else if (DEBOUNCE == 1) begin
            do_release = 1'b1;
          end else begin
            cnt_n   = DB_W'(1);
            state_n = REL_DB;
          end
        end
        REL_DB: begin
          if (match_key) begin
            cnt_n   = '0;
            state_n = HELD;
          end else if (cnt_inc == DB_W'(DEBOUNCE)) begin
            do_release = 1'b1;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    if (do_accept) begin
      code_n  = cand_n;
      valid_n = 1'b1;
      held_n  = 1'b1;
      cnt_n   = '0;
      rep_n   = '0;
      state_n = HELD;
    end
    if (do_release) begin
      held_n    = 1'b0;
      release_n = 1'b1;
      cnt_n     = '0;
      state_n   = IDLE;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench: two scanners (no repeat / repeat every 5 frames) on a modelled key matrix.
module tb_keypad_scanner;

  localparam int unsigned NR = 4;
  localparam int unsigned NC = 4;

  typedef struct packed {
    logic        valid;
    logic        rel;
    logic [3:0]  code;
    logic [31:0] t;
  } ev_t;

  typedef struct packed {
    logic [3:0] cols;
    logic       valid;
    logic [3:0] code;
    logic       held;
    logic       rel;
    logic       multi;
    logic       held_b;
    logic       multi_b;
  } snap_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] keys_a = '0;
  logic [15:0] keys_b = '0;
  logic [NC-1:0] cols_a, cols_b;
  logic [NR-1:0] rows_a, rows_b;
  logic valid_a, held_a, release_a, multi_a;
  logic valid_b, held_b, release_b, multi_b;
  logic [3:0] code_a, code_b;

  int unsigned t;
  int compared = 0;
  int mismatched = 0;
  logic snap_req = 1'b0;
  logic done_req = 1'b0;
  logic fin = 1'b0;

  ev_t   qa[$];
  ev_t   qb[$];
  snap_t qs[$];
  int    qs_id[$];
  ev_t   got_e, exp_e;
  snap_t got_s, exp_s;
  int    sid;

  always #5 clk = ~clk;

  // Cycles since the last reset edge; frame k completes on edge 16k.
  always_ff @(posedge clk) t <= reset ? 32'd0 : t + 32'd1;

  // Key matrix: a pressed key shorts its column strobe onto its row line.
  always_comb begin
    rows_a = '0;
    rows_b = '0;
    for (int c = 0; c < int'(NC); c++) begin
      for (int r = 0; r < int'(NR); r++) begin
        if (cols_a[c] && keys_a[c*NR + r]) rows_a[r] = 1'b1;
        if (cols_b[c] && keys_b[c*NR + r]) rows_b[r] = 1'b1;
      end
    end
  end

  keypad_scanner #(.N_ROWS(NR), .N_COLS(NC), .SCAN_DIV(4), .DEBOUNCE(3), .REPEAT_FRAMES(0)) dut_a (
    .clk(clk), .reset(reset), .cols(cols_a), .rows(rows_a), .key_valid(valid_a),
    .key_code(code_a), .key_held(held_a), .key_release(release_a), .multi_key(multi_a));

  keypad_scanner #(.N_ROWS(NR), .N_COLS(NC), .SCAN_DIV(4), .DEBOUNCE(3), .REPEAT_FRAMES(5)) dut_b (
    .clk(clk), .reset(reset), .cols(cols_b), .rows(rows_b), .key_valid(valid_b),
    .key_code(code_b), .key_held(held_b), .key_release(release_b), .multi_key(multi_b));

  // Monitor: owns all comparison counters.
  always @(negedge clk) begin
    if (valid_a || release_a) begin
      got_e = {valid_a, release_a, code_a, 32'(t)};
      compared++;
      if (qa.size() == 0) begin
        mismatched++;
        $display("FAIL a_event: got v=%0d r=%0d code=%0d t=%0d, expected no event", valid_a, release_a, code_a, t);
      end else begin
        exp_e = qa.pop_front();
        if (got_e !== exp_e) begin
          mismatched++;
          $display("FAIL a_event: got v=%0d r=%0d code=%0d t=%0d, expected v=%0d r=%0d code=%0d t=%0d",
                   got_e.valid, got_e.rel, got_e.code, got_e.t, exp_e.valid, exp_e.rel, exp_e.code, exp_e.t);
        end
      end
    end
    if (valid_b || release_b) begin
      got_e = {valid_b, release_b, code_b, 32'(t)};
      compared++;
      if (qb.size() == 0) begin
        mismatched++;
        $display("FAIL b_event: got v=%0d r=%0d code=%0d t=%0d, expected no event", valid_b, release_b, code_b, t);
      end else begin
        exp_e = qb.pop_front();
        if (got_e !== exp_e) begin
          mismatched++;
          $display("FAIL b_event: got v=%0d r=%0d code=%0d t=%0d, expected v=%0d r=%0d code=%0d t=%0d",
                   got_e.valid, got_e.rel, got_e.code, got_e.t, exp_e.valid, exp_e.rel, exp_e.code, exp_e.t);
        end
      end
    end
    if (snap_req && qs.size() > 0) begin
      exp_s = qs.pop_front();
      sid   = qs_id.pop_front();
      got_s = {cols_a, valid_a, code_a, held_a, release_a, multi_a, held_b, multi_b};
      compared++;
      if (got_s !== exp_s) begin
        mismatched++;
        $display("FAIL snap%0d: got cols=%b v=%0d code=%0d held=%0d rel=%0d multi=%0d hb=%0d mb=%0d, expected cols=%b v=%0d code=%0d held=%0d rel=%0d multi=%0d hb=%0d mb=%0d",
                 sid, got_s.cols, got_s.valid, got_s.code, got_s.held, got_s.rel, got_s.multi, got_s.held_b, got_s.multi_b,
                 exp_s.cols, exp_s.valid, exp_s.code, exp_s.held, exp_s.rel, exp_s.multi, exp_s.held_b, exp_s.multi_b);
      end
    end
    if (done_req && !fin) begin
      while (qa.size() > 0) begin
        exp_e = qa.pop_front();
        compared++;
        mismatched++;
        $display("FAIL a_missing: got no event, expected v=%0d r=%0d code=%0d t=%0d", exp_e.valid, exp_e.rel, exp_e.code, exp_e.t);
      end
      while (qb.size() > 0) begin
        exp_e = qb.pop_front();
        compared++;
        mismatched++;
        $display("FAIL b_missing: got no event, expected v=%0d r=%0d code=%0d t=%0d", exp_e.valid, exp_e.rel, exp_e.code, exp_e.t);
      end
      fin = 1'b1;
    end
  end

  function automatic ev_t mk(input logic rel, input logic [3:0] code, input int unsigned tt);
    ev_t e;
    e.valid = ~rel;
    e.rel   = rel;
    e.code  = code;
    e.t     = 32'(tt);
    return e;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
  endtask

  task automatic snap(input int id, input logic [3:0] code, input logic held, input logic multi, input logic hb);
    snap_t s;
    s.cols    = 4'(1 << ((t / 4) % 4));
    s.valid   = 1'b0;
    s.code    = code;
    s.held    = held;
    s.rel     = 1'b0;
    s.multi   = multi;
    s.held_b  = hb;
    s.multi_b = 1'b0;
    qs.push_back(s);
    qs_id.push_back(id);
    snap_req = 1'b1;
    @(negedge clk);
    #1;
    snap_req = 1'b0;
  endtask

  initial begin
    // Clean press of code 6 (row 2, column 1), then release.
    do_reset();
    snap(0, 4'd0, 1'b0, 1'b0, 1'b0);
    keys_a = 16'h0040;
    qa.push_back(mk(1'b0, 4'd6, 49));
    qa.push_back(mk(1'b1, 4'd6, 129));
    cycles(80);
    snap(1, 4'd6, 1'b1, 1'b0, 1'b0);
    keys_a = '0;
    cycles(64);
    snap(2, 4'd6, 1'b0, 1'b0, 1'b0);

    // Bounce: present, present, absent, then present for three frames.
    do_reset();
    keys_a = 16'h0040;
    qa.push_back(mk(1'b0, 4'd6, 97));
    qa.push_back(mk(1'b1, 4'd6, 145));
    cycles(32);
    keys_a = '0;
    cycles(16);
    keys_a = 16'h0040;
    cycles(48);
    snap(3, 4'd0, 1'b0, 1'b0, 1'b0);
    cycles(2);
    snap(4, 4'd6, 1'b1, 1'b0, 1'b0);
    keys_a = '0;
    cycles(62);

    // Two keys at once: multi_key every frame, never a key event.
    do_reset();
    keys_a = 16'h8001;
    for (int k = 1; k <= 5; k++) begin
      cycles(k == 1 ? 18 : 16);
      snap(10 + k, 4'd0, 1'b0, 1'b1, 1'b0);
    end
    cycles(14);
    keys_a = '0;
    cycles(18);
    snap(16, 4'd0, 1'b0, 1'b0, 1'b0);

    // Code 9 held for 20 frames on both scanners; B auto-repeats every 5 frames.
    do_reset();
    keys_a = 16'h0200;
    keys_b = 16'h0200;
    qa.push_back(mk(1'b0, 4'd9, 49));
    qa.push_back(mk(1'b1, 4'd9, 369));
    qb.push_back(mk(1'b0, 4'd9, 49));
    qb.push_back(mk(1'b0, 4'd9, 129));
    qb.push_back(mk(1'b0, 4'd9, 209));
    qb.push_back(mk(1'b0, 4'd9, 289));
    qb.push_back(mk(1'b1, 4'd9, 369));
    cycles(320);
    snap(20, 4'd9, 1'b1, 1'b0, 1'b1);
    keys_a = '0;
    keys_b = '0;
    cycles(64);
    snap(21, 4'd9, 1'b0, 1'b0, 1'b0);

    // Release glitch: one empty frame while held is absorbed.
    do_reset();
    keys_a = 16'h0200;
    qa.push_back(mk(1'b0, 4'd9, 49));
    cycles(80);
    keys_a = '0;
    cycles(16);
    keys_a = 16'h0200;
    cycles(48);
    snap(30, 4'd9, 1'b1, 1'b0, 1'b0);
    keys_a = '0;
    qa.push_back(mk(1'b1, 4'd9, 193));
    cycles(64);
    snap(31, 4'd9, 1'b0, 1'b0, 1'b0);

    // Reset during the second frame of a press restarts the debounce from scratch.
    keys_a = 16'h0040;
    cycles(21);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    snap(40, 4'd0, 1'b0, 1'b0, 1'b0);
    qa.push_back(mk(1'b0, 4'd6, 49));
    cycles(64);
    snap(41, 4'd6, 1'b1, 1'b0, 1'b0);
    keys_a = '0;
    qa.push_back(mk(1'b1, 4'd6, 113));
    cycles(64);
    snap(42, 4'd6, 1'b0, 1'b0, 1'b0);

    done_req = 1'b1;
    wait (fin);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run by time %0t, expected completion", $time);
    $fatal(1);
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Parametrised matrix-keypad scanner for the calculator front end. It drives one-hot column strobes, samples synchronised row inputs, and builds a full-matrix frame per scan. It debounces the frame and emits a single-cycle key event with a linear key code; mapping codes to number, operator or equals is done downstream. It adds configurable matrix size, scan rate, debounce depth, multi-key rejection, release events and optional auto-repeat.

Parameters:
N_ROWS, 4, number of row inputs (2..8)
N_COLS, 4, number of column strobes (2..8)
SCAN_DIV, 1000, clk cycles each column is driven (dwell), >=4
DEBOUNCE, 4, consecutive identical frames required to accept a press or release, >=1
REPEAT_FRAMES, 0, frames between auto-repeat key_valid pulses while held; 0 disables repeat
CODE_W, $clog2(N_ROWS*N_COLS), key_code width (derived, not overridden)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
cols  out  N_COLS  one-hot column strobe, active-high
rows  in  N_ROWS  raw row lines, active-high, asynchronous
key_valid  out  1  one-cycle pulse: key accepted (or repeated)
key_code  out  CODE_W  col_index*N_ROWS + row_index of the accepted key; stable until the next accept
key_held  out  1  high while an accepted key is held
key_release  out  1  one-cycle pulse when the held key is released
multi_key  out  1  high for one frame when the last completed frame had more than one key

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high.
- Reset values: cols=1 (column 0), key_valid=0, key_code=0, key_held=0, key_release=0, multi_key=0. The synchroniser, dwell counter, frame register, debounce counter and repeat counter all clear. The FSM goes to IDLE.
- Rows pass through a 2-flop synchroniser before use.
- Dwell counter counts 0..SCAN_DIV-1. Rows are sampled on the cycle the count is SCAN_DIV-1. On that same edge cols rotates left, wrapping from column N_COLS-1 to column 0.
- Frame: N_COLS consecutive dwells starting at column 0, giving an N_ROWS*N_COLS bit vector. At frame end the vector is classified as NONE (no bits set), SINGLE(code) (exactly one bit set) or MULTI (two or more bits set).
- A MULTI frame asserts multi_key for the next frame period. For debounce it counts as "not the candidate key".
- FSM states and transitions, evaluated only at frame end:
  - IDLE: SINGLE(c) latches candidate=c, sets cnt=1 and goes to PRESS_DB. If DEBOUNCE=1 it accepts immediately instead.
  - PRESS_DB: SINGLE(candidate) increments cnt; when cnt reaches DEBOUNCE it accepts. Any other frame returns to IDLE; a SINGLE(c') in that case restarts PRESS_DB with candidate c'.
  - Accept: key_code<=candidate, key_valid pulses in the cycle after the frame-end edge, key_held<=1, go to HELD.
  - HELD: SINGLE(key_code) keeps the state. If REPEAT_FRAMES>0, key_valid re-pulses every REPEAT_FRAMES frames. Any other frame sets cnt=1 and goes to REL_DB (or releases directly if DEBOUNCE=1).
  - REL_DB: a non-matching frame increments cnt; at DEBOUNCE it releases. SINGLE(key_code) returns to HELD without emitting a key_valid pulse.
  - Release: key_held<=0, key_release pulses, go to IDLE. The next press needs a full debounce from IDLE; rollover to a second key is not supported.
- key_valid and key_release are never asserted in the same cycle.
- Reset mid-frame or mid-debounce discards the partial frame and all counts. No key_valid or key_release is emitted because of the reset.
- Press latency from a stable key: at most (DEBOUNCE+1)*N_COLS*SCAN_DIV + 3 cycles.

Decomposition:
- Shared package keypad_pkg holds:
  - the FSM state enum (IDLE, PRESS_DB, HELD, REL_DB);
  - the frame class enum (NONE, SINGLE, MULTI);
  - the default key-code constants (KEY_0..KEY_9, KEY_PLUS, KEY_MIN, KEY_EQ) for the 4x4 layout, used by the downstream decoder.
- One sub-module, keypad_col_scan, contains the synchroniser, dwell counter, column ring and frame assembly. It outputs frame_done, frame_class and frame_code.

Test Plan:
All scenarios use N_ROWS=N_COLS=4, SCAN_DIV=4, DEBOUNCE=3, so one frame is 16 cycles.
1. Clean press: hold row 2 while column 1 is driven, for 5 frames -> exactly one key_valid with key_code=6 after the third full frame, key_held=1. Then release for 3 frames -> one key_release, key_held=0.
2. Bounce: the key is present in frames 1 and 2, absent in frame 3, present in frames 4 to 6 -> no key_valid before the end of frame 6, then key_valid with key_code=6.
3. Multi-key: row 0 at column 0 and row 3 at column 3 for 5 frames -> multi_key=1 each frame, key_valid never asserted.
4. Held key: with REPEAT_FRAMES=0, press code 9 for 20 frames -> exactly one key_valid. Rerun with REPEAT_FRAMES=5 -> key_valid at accept and then every 5 frames while held.
5. Release glitch: with code 9 held, one empty frame followed by the key again -> no key_release, no new key_valid, key_held stays 1.
6. Reset mid-debounce: assert reset for 1 cycle during frame 2 of a press -> cols=1 and all outputs 0. Keep the key held -> key_valid only 3 full frames after reset.
